// File: rtl/l2_ddr_line_mover.sv
// l2_ddr_line_mover
// DDR-side line engine for the L2 cache. It refills L2 from DDR in bursts
// of BURST_LINES 128-bit lines when the L1-facing unread level runs low.
// On a flush request it reads a burst of lines out of L2 and writes them
// back to DDR at the current window base.
//
// Ports
//   clk_166M66, mcu_sys_rst_n         clock, asynchronous active-low reset
//   i_start / i_start_line            load fetch pointer and window base (IDLE only)
//   i_fill_enable, i_l2_unread_size   automatic refill permission and L2 level
//   i_flush_req / o_flush_done        write-back request pulse / completion pulse
//   i_l1ddr_rw_confilicts             L2 port-B forbidden this cycle
//   i_ddr_base_addr_inc/_dec          L2 window-move pulses
//   o_ddr_operate_enable, o_ddr_rw,   L2 port-B: enable, 1 = write into L2,
//   o_ddr_data_bus, i_ddr_data_bus      write data, read data (1 cycle latency)
//   o_app_cmd_*, i_app_cmd_ready      DDR command handshake (rd=1 read burst)
//   i_app_rd_valid / i_app_rd_data    DDR read beats (cannot be stalled)
//   o_app_wr_*, i_app_wr_ready        DDR write beats
//   o_busy, o_window_base             status
module l2_ddr_line_mover #(
   parameter int          BURST_LINES      = 8,
   parameter logic [11:0] REFILL_THRESHOLD = 12'd256
) (
   input  logic         clk_166M66,
   input  logic         mcu_sys_rst_n,
   input  logic         i_start,
   input  logic [23:0]  i_start_line,
   input  logic         i_fill_enable,
   input  logic         i_flush_req,
   input  logic [11:0]  i_l2_unread_size,
   input  logic         i_l1ddr_rw_confilicts,
   input  logic         i_ddr_base_addr_inc,
   input  logic         i_ddr_base_addr_dec,
   output logic         o_ddr_operate_enable,
   output logic         o_ddr_rw,
   output logic [127:0] o_ddr_data_bus,
   input  logic [127:0] i_ddr_data_bus,
   output logic         o_app_cmd_valid,
   input  logic         i_app_cmd_ready,
   output logic         o_app_cmd_rd,
   output logic [27:0]  o_app_addr,
   input  logic         i_app_rd_valid,
   input  logic [127:0] i_app_rd_data,
   output logic         o_app_wr_valid,
   input  logic         i_app_wr_ready,
   output logic [127:0] o_app_wr_data,
   output logic         o_busy,
   output logic         o_flush_done,
   output logic [23:0]  o_window_base
);

   localparam int               IDX_W      = $clog2(BURST_LINES);
   localparam int               CNT_W      = IDX_W + 1;
   localparam logic [CNT_W-1:0] BURST_CNT  = CNT_W'(BURST_LINES);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
   localparam logic [23:0]      BURST_STEP = 24'(BURST_LINES);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RF_CMD  = 3'd1,
      RF_DATA = 3'd2,
      FL_RD   = 3'd3,
      FL_CMD  = 3'd4,
      FL_DATA = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [23:0]        fp_q, fp_d;
   logic [23:0]        wb_q, wb_d;
   logic [127:0]       buf_q [BURST_LINES];
   logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
   logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [CNT_W-1:0]   beat_q, beat_d;
   logic               flush_pending_q, flush_pending_d;
   logic               rd_pend_q, rd_pend_d;
   logic               cmd_valid_q, cmd_valid_d;
   logic               cmd_rd_q, cmd_rd_d;
   logic [27:0]        addr_q, addr_d;
   logic               flush_done_q, flush_done_d;

   logic               push_s;
   logic               pop_s;
   logic [127:0]       push_data_s;
   logic               l2_en_s;
   logic               l2_rw_s;
   logic [127:0]       l2_data_s;
   logic               wr_valid_s;
   logic               buf_empty_s;

   assign buf_empty_s = (count_q == {CNT_W{1'b0}});

   // Next-state, pointer, buffer-index and port-B/DDR strobe computation.
   always_comb begin
      state_d         = state_q;
      fp_d            = fp_q;
      wb_d            = wb_q;
      beat_d          = beat_q;
      flush_pending_d = flush_pending_q;
      rd_pend_d       = 1'b0;
      flush_done_d    = 1'b0;
      push_s          = 1'b0;
      pop_s           = 1'b0;
      push_data_s     = 128'd0;
      l2_en_s         = 1'b0;
      l2_rw_s         = 1'b0;
      l2_data_s       = 128'd0;
      wr_valid_s      = 1'b0;

      // Window moves apply in every state; simultaneous inc and dec cancel.
      if (i_ddr_base_addr_inc && !i_ddr_base_addr_dec) begin
         wb_d = wb_q + BURST_STEP;
      end else if (i_ddr_base_addr_dec && !i_ddr_base_addr_inc) begin
         wb_d = wb_q - BURST_STEP;
      end else begin
         wb_d = wb_q;
      end

      if (i_flush_req) begin
         flush_pending_d = 1'b1;
      end else begin
         flush_pending_d = flush_pending_q;
      end

      case (state_q)
         IDLE: begin
            if (i_start) begin
               fp_d = i_start_line;
               wb_d = i_start_line;
            end else begin
               fp_d = fp_q;
            end
            if (flush_pending_q) begin
               state_d         = FL_RD;
               flush_pending_d = 1'b0;
               beat_d          = {CNT_W{1'b0}};
            end else if (i_fill_enable && (i_l2_unread_size < REFILL_THRESHOLD)
                         && !i_l1ddr_rw_confilicts) begin
               state_d = RF_CMD;
            end else begin
               state_d = IDLE;
            end
         end

         RF_CMD: begin
            if (i_app_cmd_ready) begin
               fp_d    = fp_q + BURST_STEP;
               beat_d  = {CNT_W{1'b0}};
               state_d = RF_DATA;
            end else begin
               state_d = RF_CMD;
            end
         end

         RF_DATA: begin
            // Depth equals burst length, so a full burst always fits.
            if (i_app_rd_valid && (beat_q != BURST_CNT)) begin
               push_s      = 1'b1;
               push_data_s = i_app_rd_data;
               beat_d      = beat_q + CNT_ONE;
            end else begin
               push_s = 1'b0;
            end
            if (!buf_empty_s && !i_l1ddr_rw_confilicts) begin
               pop_s     = 1'b1;
               l2_en_s   = 1'b1;
               l2_rw_s   = 1'b1;
               l2_data_s = buf_q[rd_idx_q];
            end else begin
               pop_s = 1'b0;
            end
            // Buffer becomes empty exactly when nothing is pushed and the
            // only remaining line (if any) is popped this cycle.
            if ((beat_d == BURST_CNT) && !push_s && (count_q == CNT_W'(pop_s))) begin
               state_d = IDLE;
            end else begin
               state_d = RF_DATA;
            end
         end

         FL_RD: begin
            if ((beat_q != BURST_CNT) && !i_l1ddr_rw_confilicts) begin
               l2_en_s   = 1'b1;
               l2_rw_s   = 1'b0;
               rd_pend_d = 1'b1;
               beat_d    = beat_q + CNT_ONE;
            end else begin
               rd_pend_d = 1'b0;
            end
            // L2 read data arrives the cycle after each issued read.
            if (rd_pend_q) begin
               push_s      = 1'b1;
               push_data_s = i_ddr_data_bus;
            end else begin
               push_s = 1'b0;
            end
            if (rd_pend_q && (count_q == (BURST_CNT - CNT_ONE))) begin
               state_d = FL_CMD;
            end else begin
               state_d = FL_RD;
            end
         end

         FL_CMD: begin
            if (i_app_cmd_ready) begin
               state_d = FL_DATA;
            end else begin
               state_d = FL_CMD;
            end
         end

         FL_DATA: begin
            wr_valid_s = !buf_empty_s;
            if (wr_valid_s && i_app_wr_ready) begin
               pop_s = 1'b1;
            end else begin
               pop_s = 1'b0;
            end
            if (pop_s && (count_q == CNT_ONE)) begin
               state_d      = IDLE;
               flush_done_d = 1'b1;
            end else begin
               state_d = FL_DATA;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Buffer indices and occupancy follow the push/pop strobes.
   always_comb begin
      wr_idx_d = push_s ? (wr_idx_q + IDX_ONE) : wr_idx_q;
      rd_idx_d = pop_s  ? (rd_idx_q + IDX_ONE) : rd_idx_q;
      count_d  = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
   end

   // Command outputs are registered; the address is latched on entry so a
   // window move during the handshake cannot disturb it.
   always_comb begin
      if (state_d == RF_CMD) begin
         cmd_valid_d = 1'b1;
         cmd_rd_d    = 1'b1;
         addr_d      = {fp_d, 4'b0000};
      end else if (state_d == FL_CMD) begin
         cmd_valid_d = 1'b1;
         cmd_rd_d    = 1'b0;
         addr_d      = (state_q == FL_CMD) ? addr_q : {wb_d, 4'b0000};
      end else begin
         cmd_valid_d = 1'b0;
         cmd_rd_d    = 1'b0;
         addr_d      = 28'd0;
      end
   end

   // Control and pointer registers.
   always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
      if (!mcu_sys_rst_n) begin
         state_q         <= IDLE;
         fp_q            <= 24'd0;
         wb_q            <= 24'd0;
         wr_idx_q        <= {IDX_W{1'b0}};
         rd_idx_q        <= {IDX_W{1'b0}};
         count_q         <= {CNT_W{1'b0}};
         beat_q          <= {CNT_W{1'b0}};
         flush_pending_q <= 1'b0;
         rd_pend_q       <= 1'b0;
         cmd_valid_q     <= 1'b0;
         cmd_rd_q        <= 1'b0;
         addr_q          <= 28'd0;
         flush_done_q    <= 1'b0;
      end else begin
         state_q         <= state_d;
         fp_q            <= fp_d;
         wb_q            <= wb_d;
         wr_idx_q        <= wr_idx_d;
         rd_idx_q        <= rd_idx_d;
         count_q         <= count_d;
         beat_q          <= beat_d;
         flush_pending_q <= flush_pending_d;
         rd_pend_q       <= rd_pend_d;
         cmd_valid_q     <= cmd_valid_d;
         cmd_rd_q        <= cmd_rd_d;
         addr_q          <= addr_d;
         flush_done_q    <= flush_done_d;
      end
   end

   // Line buffer storage; emptiness is tracked by count_q, so no reset.
   always_ff @(posedge clk_166M66) begin
      if (push_s) begin
         buf_q[wr_idx_q] <= push_data_s;
      end
   end

   // Port-B strobes stay combinational so a conflict blocks them in the
   // same cycle it is raised.
   assign o_ddr_operate_enable = l2_en_s;
   assign o_ddr_rw             = l2_rw_s;
   assign o_ddr_data_bus       = l2_data_s;
   assign o_app_wr_valid       = wr_valid_s;
   assign o_app_wr_data        = wr_valid_s ? buf_q[rd_idx_q] : 128'd0;
   assign o_app_cmd_valid      = cmd_valid_q;
   assign o_app_cmd_rd         = cmd_rd_q;
   assign o_app_addr           = addr_q;
   assign o_busy               = (state_q != IDLE);
   assign o_flush_done         = flush_done_q;
   assign o_window_base        = wb_q;

endmodule
